mmio_input_conditioner: RTL and testbench
=========================================

MMIO_INPUT_CONDITIONER -- requirements
Module: mmio_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, number of consecutive clock cycles a synchronized input must differ from its debounced value before the debounced value updates; legal range 1..2^20.
REQ-002 Parameter: CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES)+1, width of each per-bit debounce counter.
REQ-003 Port: clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: key_raw  input  4  board push-buttons, asynchronous, active-low (0 = pressed).
REQ-006 Port: sw_raw  input  10  board slide switches, asynchronous, active-high.
REQ-007 Port: key_pressed  output  4  debounced keys, active-high (1 = pressed); feeds the memory block's mmio_key_in.
REQ-008 Port: sw_out  output  10  debounced switches; feeds the memory block's mmio_sw_in.
REQ-009 Port: key_press_pulse  output  4  one-cycle strobe per key on each debounced press.
REQ-010 Port: key_event  output  4  sticky per-key press flags.
REQ-011 Port: event_clear  input  4  synchronous per-bit clear for key_event.

Function
REQ-012 Each of the 14 inputs SHALL pass through a two-flop synchronizer (s1, s2) before any other logic; key bits SHALL be inverted after s2, so that 1 = pressed.
REQ-013 Per bit, on each edge: if s2 equals debounced value, counter <= 0; else if counter == DEBOUNCE_CYCLES-1, debounced <= s2 and counter <= 0; else counter <= counter+1.
REQ-014 Latency: a raw change stable from before edge k SHALL appear on the debounced output after edge k+1+DEBOUNCE_CYCLES; that is, the debounced output is visible in the cycle following that edge.
REQ-015 A difference lasting fewer than DEBOUNCE_CYCLES consecutive s2 cycles SHALL leave the debounced output unchanged and return the counter to 0.
REQ-016 The counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around is permitted.
REQ-017 key_press_pulse[i] SHALL be set at the edge where key_pressed[i] changes 0->1 and SHALL be cleared at the next edge; a release (1->0) SHALL produce no pulse.
REQ-018 key_event[i] SHALL be set at the edge where key_pressed[i] changes 0->1 and SHALL hold until event_clear[i] is sampled high.
REQ-019 If set and event_clear[i] coincide on the same edge, set SHALL win (key_event[i] = 1).
REQ-020 Switches SHALL produce no pulses or events; sw_out is level only.
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-022 While reset is high, asynchronously: key s1/s2 = 1 (released), sw s1/s2 = 0, all counters = 0, key_pressed = 0, sw_out = 0, key_press_pulse = 0, key_event = 0.
REQ-023 Reset asserted mid-count SHALL discard the count; after deassertion, no pulse/event SHALL be generated for that pending transition unless it re-qualifies for a full DEBOUNCE_CYCLES.
REQ-024 Switches already high at reset release SHALL appear on sw_out after 2+DEBOUNCE_CYCLES edges, per REQ-014.

Structure
REQ-025 Default DEBOUNCE_CYCLES value and the key/switch counts (4, 10) SHALL be defined as constants in the shared Processor.vh header.
REQ-026 One sub-module, debounce_bit (parameters DEBOUNCE_CYCLES, CNT_WIDTH, RESET_VAL; synchronizer + counter + debounced register), SHALL be instantiated 14 times; pulse/event logic SHALL reside in the top module.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Release reset; drive key_raw[0]=0 before edge 0 and hold -> key_pressed[0]=1 after edge 5; key_press_pulse[0]=1 for exactly that one cycle; key_event[0]=1 thereafter.
REQ-028 sw_raw[3]=1 for 3 cycles, then 0 -> sw_out[3] stays 0 and no output changes; sw_raw[3]=1 held -> sw_out[3]=1 after 6 edges.
REQ-029 With key_pressed[2]=1, drive key_raw[2]=1 -> key_pressed[2]=0 after 6 edges; key_press_pulse[2] stays 0; key_event[2] unchanged.
REQ-030 With key_event[1]=1, assert event_clear[1] on the same edge a new debounced press of key 1 occurs -> key_event[1]=1; a lone event_clear[1] on a later edge -> key_event[1]=0 after that edge.
REQ-031 Assert reset 2 cycles into a key_raw[3] press -> all outputs 0 immediately (asynchronously); after release with key still held -> press registers 6 edges later with exactly one pulse.
REQ-032 DEBOUNCE_CYCLES=1 build: a stable change propagates after edge k+2; a 1-cycle glitch on s2 propagates, which is the documented behaviour.

Source files
------------

// File: rtl/mmio_input_conditioner_pkg.sv
// Shared constants for the board input conditioner: default debounce window
// and the key / switch counts on the board.
package mmio_input_conditioner_pkg;

    localparam int NUM_KEYS                = 4;
    localparam int NUM_SW                  = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/debounce_bit.sv
// Purpose: two-flop synchronizer plus counter debouncer for one raw input bit.
// Latency: stable raw change visible on db after 2 + DEBOUNCE_CYCLES edges.
// Backpressure: none; free-running level path, never stalls.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES) + 1,
    // Idle level of the raw pin; db is 1 whenever the pin leaves this level.
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic db_next
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s1;
    logic                 s2;
    logic                 level;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

    assign level = s2 ^ RESET_VAL;

    // db_next is exported so the parent can strobe on the same edge db moves.
    always_comb begin
        cnt_next = cnt;
        db_next  = db;
        if (level == db) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            db_next  = level;
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= RESET_VAL;
            s2  <= RESET_VAL;
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            cnt <= cnt_next;
            db  <= db_next;
        end
    end

endmodule

// File: rtl/mmio_input_conditioner.sv
// Purpose: debounce board keys/switches for MMIO; key press strobes and sticky flags.
// Latency: 2 + DEBOUNCE_CYCLES edges from a stable raw change to every output.
// Backpressure: none; event flags hold until cleared via event_clear.
module mmio_input_conditioner
    import mmio_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_SW-1:0]   sw_out,
    output logic [NUM_KEYS-1:0] key_press_pulse,
    output logic [NUM_KEYS-1:0] key_event,
    input  logic [NUM_KEYS-1:0] event_clear
);

    logic [NUM_KEYS-1:0] key_next;
    logic [NUM_SW-1:0]   sw_next_unused;
    logic [NUM_KEYS-1:0] key_rise;

    // Keys idle high (active-low buttons), so RESET_VAL=1 also inverts them.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH),
            .RESET_VAL      (1'b1)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (key_raw[i]),
            .db     (key_pressed[i]),
            .db_next(key_next[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH),
            .RESET_VAL      (1'b0)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .db     (sw_out[i]),
            .db_next(sw_next_unused[i])
        );
    end

    assign key_rise = key_next & ~key_pressed;

    // A new press beats a coincident clear so no press is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_press_pulse <= '0;
            key_event       <= '0;
        end else begin
            key_press_pulse <= key_rise;
            key_event       <= (key_event & ~event_clear) | key_rise;
        end
    end

endmodule

// File: tb/tb_mmio_input_conditioner.sv
// Directed bench for mmio_input_conditioner at DEBOUNCE_CYCLES=4, plus a
// DEBOUNCE_CYCLES=1 instance for the minimum-window behaviour.
module tb_mmio_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_raw;
    logic [9:0] sw_raw;
    logic [3:0] event_clear;
    logic [3:0] key_pressed, key_press_pulse, key_event;
    logic [9:0] sw_out;
    logic [3:0] key_pressed1, key_press_pulse1, key_event1;
    logic [9:0] sw_out1;
    logic [3:0] pulse_or;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_input_conditioner #(.DEBOUNCE_CYCLES(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .key_raw        (key_raw),
        .sw_raw         (sw_raw),
        .key_pressed    (key_pressed),
        .sw_out         (sw_out),
        .key_press_pulse(key_press_pulse),
        .key_event      (key_event),
        .event_clear    (event_clear)
    );

    mmio_input_conditioner #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .key_raw        (key_raw),
        .sw_raw         (sw_raw),
        .key_pressed    (key_pressed1),
        .sw_out         (sw_out1),
        .key_press_pulse(key_press_pulse1),
        .key_event      (key_event1),
        .event_clear    (event_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, ending on the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Like tick, but accumulates every key strobe seen along the way.
    task automatic watch(input int n, output logic [3:0] seen);
        seen = '0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            seen |= key_press_pulse;
        end
    endtask

    initial begin
        reset       = 1'b1;
        key_raw     = 4'hF;
        sw_raw      = '0;
        event_clear = '0;
        tick(3);
        check("rst_key_pressed", 32'(key_pressed), 32'h0);
        check("rst_sw_out", 32'(sw_out), 32'h0);
        check("rst_pulse", 32'(key_press_pulse), 32'h0);
        check("rst_event", 32'(key_event), 32'h0);
        reset = 1'b0;
        tick(3);

        // Key 0 press: visible after edge 5, single strobe, sticky flag.
        key_raw[0] = 1'b0;
        tick(5);
        check("k0_before_edge5", 32'(key_pressed), 32'h0);
        tick(1);
        check("k0_pressed", 32'(key_pressed), 32'h1);
        check("k0_pulse", 32'(key_press_pulse), 32'h1);
        check("k0_event", 32'(key_event), 32'h1);
        tick(1);
        check("k0_pulse_gone", 32'(key_press_pulse), 32'h0);
        check("k0_event_held", 32'(key_event), 32'h1);

        // Switch 3 high for 3 cycles only; the window-1 build follows it at k+2.
        sw_raw[3] = 1'b1;
        tick(2);
        check("dc1_sw3_edge1", 32'(sw_out1), 32'h0);
        tick(1);
        check("dc1_sw3_edge2", 32'(sw_out1), 32'h8);
        sw_raw[3] = 1'b0;
        watch(8, pulse_or);
        check("sw3_short_out", 32'(sw_out), 32'h0);
        check("sw3_short_pulse", 32'(pulse_or), 32'h0);
        check("sw3_short_keys", 32'(key_pressed), 32'h1);
        check("sw3_short_event", 32'(key_event), 32'h1);
        sw_raw[3] = 1'b1;
        tick(5);
        check("sw3_before_edge5", 32'(sw_out), 32'h0);
        tick(1);
        check("sw3_set", 32'(sw_out), 32'h8);
        check("sw3_no_event", 32'(key_event), 32'h1);

        // Window-1 build: a single-cycle glitch passes through two edges later.
        sw_raw[5] = 1'b1;
        tick(1);
        sw_raw[5] = 1'b0;
        tick(1);
        check("dc1_glitch_edge1", 32'(sw_out1), 32'h8);
        tick(1);
        check("dc1_glitch_edge2", 32'(sw_out1), 32'h28);
        check("dc4_glitch_ignored", 32'(sw_out), 32'h8);
        tick(1);
        check("dc1_glitch_edge3", 32'(sw_out1), 32'h8);
        tick(4);

        // Key 2 press then release: release gives no strobe, flag unchanged.
        key_raw[2] = 1'b0;
        tick(6);
        check("k2_pressed", 32'(key_pressed), 32'h5);
        check("k2_pulse", 32'(key_press_pulse), 32'h4);
        tick(2);
        key_raw[2] = 1'b1;
        watch(5, pulse_or);
        check("k2_rel_before", 32'(key_pressed), 32'h5);
        watch(1, pulse_or);
        check("k2_released", 32'(key_pressed), 32'h1);
        check("k2_rel_pulse", 32'(pulse_or), 32'h0);
        check("k2_rel_event", 32'(key_event), 32'h5);

        // Key 1: set flag, release, re-press with a coincident clear.
        key_raw[1] = 1'b0;
        tick(6);
        check("k1_event_set", 32'(key_event), 32'h7);
        key_raw[1] = 1'b1;
        tick(8);
        check("k1_released", 32'(key_pressed), 32'h1);
        key_raw[1] = 1'b0;
        tick(5);
        event_clear[1] = 1'b1;
        tick(1);
        event_clear[1] = 1'b0;
        check("k1_set_wins", 32'(key_event), 32'h7);
        check("k1_repress_pulse", 32'(key_press_pulse), 32'h2);
        tick(2);
        event_clear[1] = 1'b1;
        tick(1);
        event_clear[1] = 1'b0;
        check("k1_cleared", 32'(key_event), 32'h5);

        // Reset two cycles into a key 3 press, with key 0 still held.
        key_raw = 4'b1110;
        tick(8);
        key_raw = 4'b0110;
        tick(2);
        reset = 1'b1;
        #2;
        check("arst_key_pressed", 32'(key_pressed), 32'h0);
        check("arst_sw_out", 32'(sw_out), 32'h0);
        check("arst_pulse", 32'(key_press_pulse), 32'h0);
        check("arst_event", 32'(key_event), 32'h0);
        tick(2);
        reset = 1'b0;
        watch(5, pulse_or);
        check("post_rst_early_keys", 32'(key_pressed), 32'h0);
        check("post_rst_early_pulse", 32'(pulse_or), 32'h0);
        tick(1);
        check("post_rst_keys", 32'(key_pressed), 32'h9);
        check("post_rst_pulse", 32'(key_press_pulse), 32'h9);
        check("post_rst_event", 32'(key_event), 32'h9);
        check("post_rst_sw", 32'(sw_out), 32'h8);
        watch(4, pulse_or);
        check("post_rst_one_pulse", 32'(pulse_or), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
